// File: rtl/afe4490_pkg.sv
// Shared constants, register map and FSM encoding for the AFE4490 SPI target model.
// Build option: AFE_SW_RESET_EN (consumed by afe4490_spi_target).
package afe4490_pkg;

    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 24;

    localparam logic [ADDR_BITS-1:0] CONTROL0      = 8'h00;
    localparam logic [ADDR_BITS-1:0] RW_LAST       = 8'h29;
    localparam logic [ADDR_BITS-1:0] LED2VAL       = 8'h2A;
    localparam logic [ADDR_BITS-1:0] ALED2VAL      = 8'h2B;
    localparam logic [ADDR_BITS-1:0] LED1VAL       = 8'h2C;
    localparam logic [ADDR_BITS-1:0] ALED1VAL      = 8'h2D;
    localparam logic [ADDR_BITS-1:0] LED2_ALED2VAL = 8'h2E;
    localparam logic [ADDR_BITS-1:0] LED1_ALED1VAL = 8'h2F;
    localparam logic [ADDR_BITS-1:0] DIAG          = 8'h30;
    localparam logic [ADDR_BITS-1:0] REG_LAST      = 8'h30;
    localparam logic [ADDR_BITS-1:0] SAMPLE_BASE   = LED2VAL;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT,
        ST_WAIT
    } state_e;

    // CONTROL0 is write-only and DIAG always reads zero, so neither is readable.
    function automatic logic is_readable(input logic [ADDR_BITS-1:0] a);
        return (a >= 8'h01) && (a <= LED1_ALED1VAL);
    endfunction

    function automatic logic is_rw(input logic [ADDR_BITS-1:0] a);
        return (a >= 8'h01) && (a <= RW_LAST);
    endfunction

endpackage

// File: rtl/afe4490_spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by registered
// rise/fall detection; o_level is the synchronized value aligned with the events.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_level = prev_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/afe4490_spi_target.sv
// SPI (CPOL 0 / CPHA 0) responder emulating the AFE4490 register file 0x00..0x30.
// Define AFE_SW_RESET_EN to let CONTROL0 bit3 clear the register file.
module afe4490_spi_target
    import afe4490_pkg::*;
#(
    parameter int NUM_REGS    = 49,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sclk,
    input  logic                 i_cs_n,
    input  logic                 i_mosi,
    output logic                 o_miso,
    input  logic                 i_smp_valid,
    input  logic [2:0]           i_smp_idx,
    input  logic [DATA_BITS-1:0] i_smp_data,
    output logic                 o_frame_done,
    output logic                 o_wr_pulse,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [DATA_BITS-1:0] o_wr_data
);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_rise, cs_fall, cs_lvl;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_ok;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
        .o_level(sclk_lvl), .o_rise(sclk_rise), .o_fall(sclk_fall));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs_n),
        .o_level(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
        .o_level(mosi_lvl), .o_rise(mosi_rise), .o_fall(mosi_fall));

    assign unused_ok = &{1'b0, sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic                 frame_done_q, frame_done_d;
    logic                 wr_pulse_q, wr_pulse_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 r_spi_read_q, r_spi_read_d;
    logic [DATA_BITS-1:0] regs_q [NUM_REGS];
    logic [DATA_BITS-1:0] regs_d [NUM_REGS];
    logic [5:0]           smp_addr;
`ifdef AFE_SW_RESET_EN
    logic                 sw_rst_q, sw_rst_d;
`endif

    assign smp_addr = SAMPLE_BASE[5:0] + {3'b000, i_smp_idx};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        wr_pulse_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        r_spi_read_d = r_spi_read_q;
        regs_d       = regs_q;
`ifdef AFE_SW_RESET_EN
        sw_rst_d     = 1'b0;
`endif

        if (i_smp_valid && (i_smp_idx < 3'd6))
            regs_d[smp_addr] = i_smp_data;

`ifdef AFE_SW_RESET_EN
        // Soft reset lands the cycle after the CONTROL0 commit and wins over sample writes.
        if (sw_rst_q) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_d[i] = '0;
            r_spi_read_d = 1'b0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (cs_fall)
                    state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    addr_d = {addr_q[ADDR_BITS-2:0], mosi_lvl};
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                        // regs_q, not regs_d: a same-cycle sample write shows up next frame.
                        tx_d = (r_spi_read_q && is_readable(addr_d)) ? regs_q[addr_d[5:0]] : '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        miso_d = tx_q[DATA_BITS-1];
                        tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d = {rx_q[DATA_BITS-2:0], mosi_lvl};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d    = '0;
                            state_d      = ST_COMMIT;
                            frame_done_d = 1'b1;
                            if ((addr_q == CONTROL0) || (!r_spi_read_q && is_rw(addr_q))) begin
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = addr_q;
                                wr_data_d  = rx_d;
                                if (addr_q == CONTROL0) begin
                                    r_spi_read_d = rx_d[0];
`ifdef AFE_SW_RESET_EN
                                    sw_rst_d     = rx_d[3];
`endif
                                end else begin
                                    regs_d[addr_q[5:0]] = rx_d;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                miso_d  = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                miso_d = 1'b0;
                if (cs_rise)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_pulse_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            r_spi_read_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
`ifdef AFE_SW_RESET_EN
            sw_rst_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            wr_pulse_q   <= wr_pulse_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            r_spi_read_q <= r_spi_read_d;
            regs_q       <= regs_d;
`ifdef AFE_SW_RESET_EN
            sw_rst_q     <= sw_rst_d;
`endif
        end
    end

    assign o_miso       = miso_q;
    assign o_frame_done = frame_done_q;
    assign o_wr_pulse   = wr_pulse_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_afe4490_spi_target.sv
// Self-checking bench for afe4490_spi_target: directed vector table, hand-written
// abort/reset sequences, and random frames checked against a register-map model.
`timescale 1ns/1ps
module tb_afe4490_spi_target;

    localparam int H = 6;  // i_clk cycles per sclk phase

    logic        clk = 1'b0;
    logic        rst, sclk, cs_n, mosi, smp_valid;
    logic [2:0]  smp_idx;
    logic [23:0] smp_data;
    logic        miso, frame_done, wr_pulse;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;

    always #5 clk = ~clk;

    afe4490_spi_target #(.NUM_REGS(49), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .i_smp_valid(smp_valid), .i_smp_idx(smp_idx),
        .i_smp_data(smp_data), .o_frame_done(frame_done), .o_wr_pulse(wr_pulse),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data));

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int fd_cnt   = 0;
    logic [7:0]  last_wa = '0;
    logic [23:0] last_wd = '0;

    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_cnt  = wr_cnt + 1;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    // Reference: the register map as the master sees it.
    logic [23:0] m_regs [0:255];
    bit          m_spi_read;

    task automatic model_frame(input logic [7:0] a, input logic [23:0] d,
                               output logic [23:0] rd, output bit wr);
        bit readable, writable;
        readable = (a >= 8'h01) && (a <= 8'h2F);
        writable = (a >= 8'h01) && (a <= 8'h29);
        rd = (m_spi_read && readable) ? m_regs[a] : 24'h0;
        wr = (a == 8'h00) || (!m_spi_read && writable);
        if (wr) begin
            if (a == 8'h00) begin
                m_spi_read = d[0];
`ifdef AFE_SW_RESET_EN
                if (d[3]) begin
                    for (int i = 0; i < 256; i++) m_regs[i] = 24'h0;
                    m_spi_read = 1'b0;
                end
`endif
            end else begin
                m_regs[a] = d;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n, output logic [23:0] rd);
        rd = 24'h0;
        for (int i = 0; i < n; i++) begin
            mosi = w[31-i];
            repeat (H) @(negedge clk);
            if (i >= 8) rd = {rd[22:0], miso};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] a, input logic [23:0] d, output logic [23:0] rd);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits({a, d}, 32, rd);
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic smp_write(input logic [2:0] idx, input logic [23:0] d);
        @(negedge clk);
        smp_valid = 1'b1;
        smp_idx   = idx;
        smp_data  = d;
        @(negedge clk);
        smp_valid = 1'b0;
        if (idx < 3'd6) m_regs[8'h2A + 8'(idx)] = d;
    endtask

    task automatic frame_check(input string tag, input logic [7:0] a, input logic [23:0] d,
                               input logic [23:0] exp_rd, input bit exp_wr);
        int wr0, fd0;
        logic [23:0] rd, m_rd;
        bit m_wr;
        wr0 = wr_cnt;
        fd0 = fd_cnt;
        spi_frame(a, d, rd);
        model_frame(a, d, m_rd, m_wr);
        chk({tag, ".miso"}, 32'(rd), 32'(exp_rd));
        chk({tag, ".wr_pulse_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        chk({tag, ".frame_done_count"}, 32'(fd_cnt - fd0), 32'd1);
        if (exp_wr) begin
            chk({tag, ".wr_addr"}, 32'(last_wa), 32'(a));
            chk({tag, ".wr_data"}, 32'(last_wd), 32'(d));
        end
    endtask

    typedef struct {
        bit          smp;
        logic [2:0]  idx;
        logic [23:0] sdata;
        logic [7:0]  addr;
        logic [23:0] data;
        logic [23:0] exp_rd;
        bit          exp_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit s, logic [2:0] i, logic [23:0] sd, logic [7:0] a,
                                logic [23:0] d, logic [23:0] rd, bit w);
        vec_t v;
        v = '{s, i, sd, a, d, rd, w};
        vecs.push_back(v);
    endfunction

    initial begin
        logic [23:0] rd, m_rd;
        logic [7:0]  a;
        logic [23:0] d;
        bit          m_wr;
        int          wr0, fd0;

        for (int i = 0; i < 256; i++) m_regs[i] = 24'h0;
        m_spi_read = 1'b0;

        add(0, 0, 0,         8'h20, 24'h004C0F, 24'h0,      1);
        add(0, 0, 0,         8'h00, 24'h000001, 24'h0,      1);
        add(0, 0, 0,         8'h20, 24'h000000, 24'h004C0F, 0);
        add(0, 0, 0,         8'h01, 24'h0017C0, 24'h0,      0);
        add(0, 0, 0,         8'h01, 24'h000000, 24'h0,      0);
        add(0, 0, 0,         8'h3F, 24'h777777, 24'h0,      0);
        add(0, 0, 0,         8'h00, 24'h000001, 24'h0,      1);
        add(1, 2, 24'hABCDEF, 8'h2C, 24'h000000, 24'hABCDEF, 0);
        add(0, 0, 0,         8'h00, 24'h000000, 24'h0,      1);
        add(0, 0, 0,         8'h2C, 24'h123456, 24'h0,      0);
        add(0, 0, 0,         8'h30, 24'h0000AA, 24'h0,      0);
        add(1, 6, 24'h555555, 8'h00, 24'h000001, 24'h0,      1);
        add(0, 0, 0,         8'h2C, 24'h000000, 24'hABCDEF, 0);
        add(0, 0, 0,         8'h30, 24'h000000, 24'h0,      0);
        add(0, 0, 0,         8'h00, 24'h000000, 24'h0,      1);
        add(0, 0, 0,         8'h21, 24'h000005, 24'h0,      1);
        add(0, 0, 0,         8'h00, 24'h000008, 24'h0,      1);
        add(0, 0, 0,         8'h00, 24'h000001, 24'h0,      1);
`ifdef AFE_SW_RESET_EN
        add(0, 0, 0,         8'h21, 24'h000000, 24'h000000, 0);
        add(0, 0, 0,         8'h20, 24'h000000, 24'h000000, 0);
`else
        add(0, 0, 0,         8'h21, 24'h000000, 24'h000005, 0);
        add(0, 0, 0,         8'h20, 24'h000000, 24'h004C0F, 0);
`endif
        add(1, 0, 24'h0A0B0C, 8'h2A, 24'h000000, 24'h0A0B0C, 0);

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        smp_valid = 1'b0; smp_idx = '0; smp_data = '0;
        repeat (5) @(negedge clk);
        chk("reset.miso",       32'(miso),       32'd0);
        chk("reset.frame_done", 32'(frame_done), 32'd0);
        chk("reset.wr_pulse",   32'(wr_pulse),   32'd0);
        chk("reset.wr_addr",    32'(wr_addr),    32'd0);
        chk("reset.wr_data",    32'(wr_data),    32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Reset mid-frame: with cs_n still low, a following full frame must be ignored.
        wr0 = wr_cnt; fd0 = fd_cnt;
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits({8'h05, 24'h111111}, 10, rd);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits({8'h05, 24'h111111}, 32, rd);
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
        chk("rst_mid.frame_done_count", 32'(fd_cnt - fd0), 32'd0);
        chk("rst_mid.wr_pulse_count",   32'(wr_cnt - wr0), 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].smp) smp_write(vecs[k].idx, vecs[k].sdata);
            frame_check($sformatf("vec%0d", k), vecs[k].addr, vecs[k].data,
                        vecs[k].exp_rd, vecs[k].exp_wr);
        end

        // Abort after 15 rises of a write frame, then the same frame in full.
        frame_check("abort.pre", 8'h00, 24'h000000, 24'h0, 1);
        wr0 = wr_cnt; fd0 = fd_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits({8'h22, 24'h00ABCD}, 15, rd);
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
        chk("abort.frame_done_count", 32'(fd_cnt - fd0), 32'd0);
        chk("abort.wr_pulse_count",   32'(wr_cnt - wr0), 32'd0);
        frame_check("abort.next", 8'h22, 24'h00ABCD, 24'h0, 1);
        frame_check("abort.en_read", 8'h00, 24'h000001, 24'h0, 1);
        frame_check("abort.readback", 8'h22, 24'h000000, 24'h00ABCD, 0);

        for (int n = 0; n < 60; n++) begin
            int sel;
            if ($urandom_range(0, 2) == 0)
                smp_write(3'($urandom_range(0, 7)), 24'($urandom));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 8'h00;
            else if (sel == 1) a = 8'($urandom_range(8'h31, 8'hFF));
            else               a = 8'($urandom_range(8'h01, 8'h30));
            d = 24'($urandom);
            wr0 = wr_cnt; fd0 = fd_cnt;
            spi_frame(a, d, rd);
            model_frame(a, d, m_rd, m_wr);
            chk($sformatf("rnd%0d.a%02h.miso", n, a), 32'(rd), 32'(m_rd));
            chk($sformatf("rnd%0d.a%02h.wr_pulse_count", n, a), 32'(wr_cnt - wr0), 32'(m_wr));
            chk($sformatf("rnd%0d.frame_done_count", n), 32'(fd_cnt - fd0), 32'd1);
            if (m_wr) chk($sformatf("rnd%0d.wr_data", n), 32'(last_wd), 32'(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afe4490_spi_target.md
# afe4490_spi_target

Synthesizable SPI responder that models the AFE4490 register interface, CPOL 0 / CPHA 0. It is the target end of the pulse-ox SPI master. It serves two purposes: closed-loop bench and FPGA emulation of the front end without the chip, and feeding synthetic LED/ambient samples into the sensor-read path. It holds the 0x00–0x30 register map, accepts 32-bit frames (8-bit address + 24-bit data), and honours CONTROL0 SPI_READ gating.

## Interface
- `NUM_REGS`, 49: registers 0x00..0x30.
- `SYNC_STAGES`, 2: flops per input synchronizer.
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_sclk` in 1: SPI clock from master, asynchronous.
- `i_cs_n` in 1: chip select, active-low, asynchronous.
- `i_mosi` in 1: master data, asynchronous.
- `o_miso` out 1: target data, MSB first.
- `i_smp_valid` in 1: sample-port write strobe.
- `i_smp_idx` in 3: sample-port target; 0..5 map to 0x2A..0x2F; 6..7 are ignored.
- `i_smp_data` in 24: sample value.
- `o_frame_done` out 1: 1-cycle pulse after a complete 32-bit frame.
- `o_wr_pulse` out 1: 1-cycle pulse when a register write commits.
- `o_wr_addr` out 8: address of the committed write.
- `o_wr_data` out 24: data of the committed write.

## Operation
- Inputs pass through the synchronizer and then rise/fall edge detect. Internal logic acts only on the detected events.
- **Register classes**
  - 0x00 CONTROL0: write-only; reads return 0. Bit0 SPI_READ is stored in `r_spi_read`.
  - 0x01..0x29: read/write.
  - 0x2A..0x30: read-only from SPI; 0x2A..0x2F are loaded only through the sample port; 0x30 DIAG reads 0.
  - Addresses >0x30: reads return 0; writes are dropped.
- **FSM states**
  - IDLE: `o_miso`=0, bit counter=0. A cs_n falling event moves to ADDR.
  - ADDR: each sclk rise shifts `i_mosi` into the address. On the 8th rise, latch the address and go to DATA.
    - If `r_spi_read`=1 and the address is readable, load the tx shift register with the register's current value.
    - Otherwise load 0.
  - DATA: each sclk fall drives the next tx bit on `o_miso`, starting with bit 23 on the fall after the 8th rise. Each sclk rise shifts `i_mosi` into rx data. On the 24th data rise, go to COMMIT.
  - COMMIT (1 cycle): pulse `o_frame_done`. A write commits when either of these holds:
    - address is 0x00 (always accepted), or
    - `r_spi_read`=0 and address is 0x01..0x29.

    On commit, update the register and pulse `o_wr_pulse` with `o_wr_addr`/`o_wr_data`. Then go to WAIT.
  - WAIT: ignore extra sclk edges, hold `o_miso`=0. A cs_n rising event moves to IDLE.
- A cs_n rising event in ADDR or DATA aborts the frame: no write, no `o_frame_done`, return to IDLE.
- **Sample port:** `i_smp_valid` writes `i_smp_data` to 0x2A+`i_smp_idx` the same cycle, in any FSM state.
- **Same-cycle sample write and tx load of that register:** tx gets the old value; the new value is visible on the next frame.
- **SPI_READ set in a frame's CONTROL0 write:** takes effect from the next frame.

## Timing
- Pin-to-event latency is SYNC_STAGES+1 = 3 `i_clk` cycles.
- The master must hold each sclk phase for at least 4 `i_clk` cycles. This keeps `o_miso` stable before the master samples on the next rise.
- Write commit happens 1 cycle after the 24th data rise event.
- **Reset values:**
  - All registers, `r_spi_read`, bit counter, shift registers, `o_miso`, and every output are 0.
  - State is IDLE.
- Reset asserted mid-frame discards the frame; the master must re-assert cs_n before the next frame is accepted.

## Configuration
- `AFE_SW_RESET_EN` defined: a committed CONTROL0 write with bit3 (SW_RST)=1 clears all registers and `r_spi_read` on the following cycle. `o_wr_pulse` still fires for that write.
- `AFE_SW_RESET_EN` undefined: CONTROL0 bit3 is ignored.

## Structure
- Package `afe4490_pkg` holds:
  - register address constants (CONTROL0 … DIAG, REG_LAST=0x30, SAMPLE_BASE=0x2A);
  - ADDR_BITS=8, DATA_BITS=24;
  - the FSM state enum.
- One sub-module, `spi_edge_sync`: a SYNC_STAGES synchronizer plus rise/fall detect, instantiated once per SPI input.

## Test plan
- Write frame 0x20 / 0x00_4C0F with SPI_READ=0 -> `o_wr_pulse`, `o_wr_addr`=0x20, `o_wr_data`=0x004C0F. Then write CONTROL0=0x000001 and read 0x20 -> MISO returns 0x004C0F.
- With SPI_READ=1, write 0x01=0x0017C0 -> no `o_wr_pulse`, `o_frame_done` pulses, and 0x01 keeps its prior value.
- Sample-port write idx 2 with 0xABCDEF, then SPI read 0x2C -> 0xABCDEF. SPI write to 0x2C -> dropped.
- cs_n raised after 15 sclk rises of a write frame -> no write, no `o_frame_done`. The next full frame completes normally.
- Read address 0x3F and read CONTROL0 -> 24 zero bits each.
- With `AFE_SW_RESET_EN` defined, write 0x21=0x000005, then CONTROL0=0x000008 -> 0x21 reads back 0 after re-enabling SPI_READ. With the macro undefined, it reads 0x000005.
